// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order memory reads, buffers returned words
// in a small reservation ring and hands them to decode in program order.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_stall,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   wide_t;

  logic [31:0]      pc;
  logic [31:0]      pcs [DEPTH];
  logic [31:0]      ins [DEPTH];
  logic [DEPTH-1:0] filled;

  ptr_t head;
  ptr_t tail;
  ptr_t fptr;
  cnt_t alloc;
  cnt_t pend;
  cnt_t drop_cnt;

  logic  accept;
  logic  fill;
  logic  dropr;
  logic  pop;
  wide_t occ;
  wide_t dsum;
  cnt_t  dnext;

  assign occ = wide_t'(alloc) + wide_t'(drop_cnt);

  // Request gating sees only registered state plus flush/reset.
  assign req_valid = rst && !flush
                  && (occ < wide_t'(DEPTH));
  assign req_addr  = pc;

  assign out_valid = (alloc != '0) && filled[head];
  assign out_pc    = pcs[head];
  assign out_instr = ins[head];

  assign accept = req_valid && req_ready;
  assign dropr  = resp_valid && (drop_cnt != '0);
  assign fill   = resp_valid && (drop_cnt == '0)
               && (pend != '0);
  assign pop    = out_valid && !out_stall;

  // Outstanding reads still owed to us become responses to throw away.
  assign dsum = wide_t'(drop_cnt) + wide_t'(pend);

  always_comb begin
    dnext = cnt_t'(dsum);
    if (resp_valid && (dsum != '0))
      dnext = cnt_t'(dsum - wide_t'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC & ~32'h3;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      alloc    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcs[i] <= '0;
        ins[i] <= '0;
      end
    end else if (flush) begin
      pc       <= flush_pc & ~32'h3;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      alloc    <= '0;
      pend     <= '0;
      drop_cnt <= dnext;
      filled   <= '0;
    end else begin
      if (accept) begin
        pcs[tail]    <= pc;
        filled[tail] <= 1'b0;
        tail         <= tail + ptr_t'(1);
        pc           <= pc + 32'd4;
      end
      if (dropr)
        drop_cnt <= drop_cnt - cnt_t'(1);
      if (fill) begin
        ins[fptr]    <= resp_data;
        filled[fptr] <= 1'b1;
        fptr         <= fptr + ptr_t'(1);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + ptr_t'(1);
      end
      alloc <= alloc + cnt_t'(accept)
                     - cnt_t'(pop);
      pend  <= pend + cnt_t'(accept)
                    - cnt_t'(fill);
    end
  end

  a_resp_orphan: assert property (
    @(posedge clk) disable iff (!rst)
    !(resp_valid && (drop_cnt == '0)
      && (pend == '0))
  );

endmodule
